// File: rtl/adder_sum_accumulator.sv
// Accumulates N_SAMPLES unsigned adder sums into one total and presents it over valid/ready.
// Optional macro ACC_SATURATE_EN: clamp the total at 2^ACC_W-1 instead of wrapping.
module adder_sum_accumulator #(
  parameter int IN_W      = 5,
  parameter int ACC_W     = 8,
  parameter int N_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

`ifdef ACC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] total;
  logic             ovf_next;

  // Carry out of the widened sum either clamps to full scale or is dropped (wrap).
  function automatic logic [ACC_W-1:0] fold_sum(input logic [ACC_W:0] s);
    return (SAT_EN && s[ACC_W]) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  assign in_ready = (state == ST_ACC);

  always_comb begin
    sum      = {1'b0, acc} + (ACC_W + 1)'(in_data);
    total    = fold_sum(sum);
    ovf_next = ovf | sum[ACC_W];
  end

  // Accumulate / present boundary: the completed total is registered straight into out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            if (cnt == LAST_CNT) begin
              out_valid <= 1'b1;
              out_data  <= total;
              out_ovf   <= ovf_next;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= ST_OUT;
            end else begin
              acc <= total;
              ovf <= ovf_next;
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed + randomized bench for adder_sum_accumulator: default build, a 6-bit
// accumulator variant sharing the same stimulus, and a single-sample pass-through variant.
module tb_adder_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n, clr;
  logic       in_valid, out_ready;
  logic [4:0] in_data;
  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_data;
  logic       in_ready1, out_valid1, out_ovf1;
  logic [5:0] out_data1;
  logic       in_valid2, out_ready2;
  logic [4:0] in_data2;
  logic       in_ready2, out_valid2, out_ovf2;
  logic [7:0] out_data2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_sum_accumulator u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf),
    .out_ready(out_ready));

  adder_sum_accumulator #(.IN_W(5), .ACC_W(6), .N_SAMPLES(4)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1), .out_ovf(out_ovf1),
    .out_ready(out_ready));

  adder_sum_accumulator #(.IN_W(5), .ACC_W(8), .N_SAMPLES(1)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2), .out_ovf(out_ovf2),
    .out_ready(out_ready2));

  // Reference: a batch total is the plain integer sum of its samples.
  function automatic int model_data(input int tot, input int w);
    int full;
    full = (1 << w) - 1;
`ifdef ACC_SATURATE_EN
    return (tot > full) ? full : tot;
`else
    return tot % (1 << w);
`endif
  endfunction

  function automatic int model_ovf(input int tot, input int w);
    return (tot > (1 << w) - 1) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d[4:0];
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input int tot);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_data8"}, {24'd0, out_data}, model_data(tot, 8));
    check({tag, "_ovf8"}, {31'd0, out_ovf}, model_ovf(tot, 8));
    check({tag, "_data6"}, {26'd0, out_data1}, model_data(tot, 6));
    check({tag, "_ovf6"}, {31'd0, out_ovf1}, model_ovf(tot, 6));
  endtask

  task automatic do_batch(input string tag, input int a, input int b, input int c,
                          input int d, input bit rdy, output int tot);
    out_ready = rdy;
    send(a);
    send(b);
    send(c);
    send(d);
    tot = a + b + c + d;
    check_out(tag, tot);
    if (rdy) begin
      step();
      check({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_done_in_ready"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  task automatic stall_then_release(input string tag, input int tot, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 5'($urandom_range(0, 31));
      step();
      check_out({tag, "_stall"}, tot);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rel_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int tot;
    int s[4];
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_in_ready_n1", {31'd0, in_ready2}, 32'd1);
    rst_n = 1'b1;
    step();

    do_batch("basic", 5, 10, 15, 31, 1'b1, tot);
    do_batch("full", 31, 31, 31, 31, 1'b1, tot);

    do_batch("hold", 12, 3, 30, 8, 1'b0, tot);
    stall_then_release("hold", tot, 5);

    send(7);
    send(9);
    in_valid = 1'b1; in_data = 5'd20; clr = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_in_ready", {31'd0, in_ready}, 32'd1);
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    do_batch("after_clr", 1, 1, 1, 1, 1'b1, tot);

    do_batch("clr_pending", 20, 20, 20, 20, 1'b0, tot);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_pend_valid", {31'd0, out_valid}, 32'd0);
    check("clr_pend_in_ready", {31'd0, in_ready}, 32'd1);

    send(4); send(5); send(6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_mid_valid", {31'd0, out_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    do_batch("pre_arst", 9, 9, 9, 9, 1'b0, tot);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data", {24'd0, out_data}, 32'd0);
    check("arst_out_ovf", {31'd0, out_ovf}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    do_batch("post_arst", 2, 2, 2, 2, 1'b1, tot);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) s[i] = int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        do_batch("rand", s[0], s[1], s[2], s[3], 1'b1, tot);
      end else begin
        do_batch("rand_hold", s[0], s[1], s[2], s[3], 1'b0, tot);
        stall_then_release("rand", tot, int'($urandom_range(1, 3)));
      end
    end

    out_ready2 = 1'b1;
    in_valid2 = 1'b1; in_data2 = 5'd3;
    step();
    check("n1_first_valid", {31'd0, out_valid2}, 32'd1);
    check("n1_first_data", {24'd0, out_data2}, 32'd3);
    check("n1_first_in_ready", {31'd0, in_ready2}, 32'd0);
    in_data2 = 5'd17;
    step();
    check("n1_gap_valid", {31'd0, out_valid2}, 32'd0);
    check("n1_gap_in_ready", {31'd0, in_ready2}, 32'd1);
    step();
    in_valid2 = 1'b0;
    check("n1_second_valid", {31'd0, out_valid2}, 32'd1);
    check("n1_second_data", {24'd0, out_data2}, 32'd17);
    check("n1_second_ovf", {31'd0, out_ovf2}, 32'd0);
    check("n1_second_in_ready", {31'd0, in_ready2}, 32'd0);
    step();
    check("n1_end_valid", {31'd0, out_valid2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
